// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - conversion handshake bundle between a binary source and the display engine
interface seg7_scan_display_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic [BIN_W-1:0]    bin_in;
  logic                in_valid;
  logic                in_ready;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic                ovf;

  modport master (
    output bin_in, in_valid,
    input  in_ready, done, bcd_out, ovf
  );

  modport slave (
    input  bin_in, in_valid,
    output in_ready, done, bcd_out, ovf
  );
endinterface

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - sequential double-dabble BCD converter driving a multiplexed 7-segment display
module seg7_scan_display #(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_display_if.slave cv,
  input  logic               blank_lz,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  an
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic               sovf_q, sovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  an_q, an_d;

  logic [BCD_W-1:0]   scr_adj, scr_next;
  logic [BIN_W-1:0]   bin_next;
  logic               carry;
  logic [DIGITS-1:0]  lz;
  logic               hi_zero;
  logic [3:0]         cur;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // One double-dabble step; a bit leaving the top digit means the value needs another digit.
  always_comb begin
    scr_adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
    {carry, scr_next, bin_next} = {scr_adj, bin_q, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    sovf_d  = sovf_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cv.in_valid) begin
          bin_d   = cv.bin_in;
          scr_d   = '0;
          sovf_d  = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bin_d  = bin_next;
        scr_d  = scr_next;
        sovf_d = sovf_q | carry;
        cnt_d  = cnt_q - CNT_W'(1);
        // Publish on the final step so bcd_out changes on the same edge done rises.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scr_next;
          ovf_d   = sovf_q | carry;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    hi_zero = 1'b1;
    lz      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (bcd_q[4*k +: 4] == 4'd0);
      lz[k]   = hi_zero;
    end

    // Decode against the next index so segments and enables switch on one edge.
    cur   = bcd_q[4*idx_d +: 4];
    seg_d = seg_code(cur);
    if (ovf_q) begin
      seg_d = 7'h40;
    end else if (blank_lz && (idx_d != '0) && lz[idx_d]) begin
      seg_d = 7'h00;
    end
    an_d = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      sovf_q  <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h3F;
      an_q    <= ~DIGITS'(1);
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      sovf_q  <= sovf_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign cv.in_ready = (state_q == S_IDLE);
  assign cv.done     = done_q;
  assign cv.bcd_out  = bcd_q;
  assign cv.ovf      = ovf_q;
  assign seg         = seg_q;
  assign an          = an_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display over three parameter sets
module tb_seg7_scan_display;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bin_drv;
  logic [2:0]  vld;
  logic        blank;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan_display_if #(.BIN_W(8),  .DIGITS(3)) if_a ();
  seg7_scan_display_if #(.BIN_W(10), .DIGITS(3)) if_b ();
  seg7_scan_display_if #(.BIN_W(16), .DIGITS(5)) if_c ();

  logic [6:0] seg_a, seg_b, seg_c;
  logic [2:0] an_a, an_b;
  logic [4:0] an_c;

  assign if_a.bin_in   = bin_drv[7:0];
  assign if_b.bin_in   = bin_drv[9:0];
  assign if_c.bin_in   = bin_drv;
  assign if_a.in_valid = vld[0];
  assign if_b.in_valid = vld[1];
  assign if_c.in_valid = vld[2];

  seg7_scan_display #(.BIN_W(8),  .DIGITS(3), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .cv(if_a), .blank_lz(blank), .seg(seg_a), .an(an_a));
  seg7_scan_display #(.BIN_W(10), .DIGITS(3), .SCAN_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .cv(if_b), .blank_lz(blank), .seg(seg_b), .an(an_b));
  seg7_scan_display #(.BIN_W(16), .DIGITS(5), .SCAN_DIV(2)) dut_c (
    .clk(clk), .rst(rst), .cv(if_c), .blank_lz(blank), .seg(seg_c), .an(an_c));

  logic [2:0]  rdy, dn, ov;
  logic [19:0] bcd_w [3];
  logic [6:0]  seg_w [3];
  logic [4:0]  an_w  [3];

  assign rdy      = {if_c.in_ready, if_b.in_ready, if_a.in_ready};
  assign dn       = {if_c.done, if_b.done, if_a.done};
  assign ov       = {if_c.ovf, if_b.ovf, if_a.ovf};
  assign bcd_w[0] = {8'h00, if_a.bcd_out};
  assign bcd_w[1] = {8'h00, if_b.bcd_out};
  assign bcd_w[2] = if_c.bcd_out;
  assign seg_w[0] = seg_a;
  assign seg_w[1] = seg_b;
  assign seg_w[2] = seg_c;
  assign an_w[0]  = {2'b11, an_a};
  assign an_w[1]  = {2'b11, an_b};
  assign an_w[2]  = an_c;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    int          sel;
    int          value;
    logic [19:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  function automatic int bw(int s);  return (s == 0) ? 8 : (s == 1) ? 10 : 16; endfunction
  function automatic int dg(int s);  return (s == 2) ? 5 : 3; endfunction
  function automatic int sd(int s);  return (s == 0) ? 4 : (s == 1) ? 3 : 2; endfunction

  function automatic int pow10(int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [19:0] m_bcd(int v, int d);
    logic [19:0] r = '0;
    int m = v % pow10(d);
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] m_seg(int v, int d, int k, bit bl);
    int up;
    if (v >= pow10(d)) return 7'h40;
    up = v / pow10(k);
    if (bl && k > 0 && up == 0) return 7'h00;
    return seg_tbl[up % 10];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic convert(input int sel, input int value, input string name,
                         output logic [19:0] got_bcd, output logic got_ovf);
    bit acc = 0;
    bit rdy_bad = 0;
    int dcyc = -1;
    got_bcd = 'x;
    got_ovf = 1'bx;
    @(negedge clk);
    bin_drv  = 16'(value);
    vld[sel] = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (rdy[sel]) acc = 1;
      else @(negedge clk);
    end
    chk({name, " accept"}, 32'(acc), 32'd1);
    @(negedge clk);
    vld[sel] = 1'b0;
    for (int n = 1; n <= bw(sel) + 3; n++) begin
      if (n <= bw(sel) + 1 && rdy[sel]) rdy_bad = 1;
      if (dn[sel]) begin
        if (dcyc == -1) begin
          dcyc    = n;
          got_bcd = bcd_w[sel];
          got_ovf = ov[sel];
        end else begin
          dcyc = -2;
        end
      end
      @(negedge clk);
    end
    chk({name, " done_cycle"}, 32'(dcyc), 32'(bw(sel) + 1));
    chk({name, " ready_low"}, 32'(rdy_bad), 32'd0);
  endtask

  task automatic check_scan(input int sel, input int value, input bit bl, input string name);
    logic [4:0] prev;
    bit found = 0;
    blank = bl;
    repeat (2) @(negedge clk);
    prev = an_w[sel];
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (an_w[sel] == 5'b11110 && prev != 5'b11110) found = 1;
      prev = an_w[sel];
    end
    chk({name, " scan_sync"}, 32'(found), 32'd1);
    for (int j = 0; j < dg(sel) * sd(sel); j++) begin
      int k = j / sd(sel);
      chk({name, " an"}, 32'(an_w[sel]), 32'(5'b11111 & ~(5'd1 << k)));
      chk({name, " seg"}, 32'(seg_w[sel]), 32'(m_seg(value, dg(sel), k, bl)));
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t        tbl [9];
    logic [19:0] gb;
    logic        go;
    int          dcnt;
    int          dcyc [$];
    logic [19:0] dbcd [$];

    tbl[0] = '{0, 255,   20'h00255, 1'b0};
    tbl[1] = '{0, 0,     20'h00000, 1'b0};
    tbl[2] = '{0, 100,   20'h00100, 1'b0};
    tbl[3] = '{1, 1000,  20'h00000, 1'b1};
    tbl[4] = '{1, 999,   20'h00999, 1'b0};
    tbl[5] = '{1, 1023,  20'h00023, 1'b1};
    tbl[6] = '{2, 65535, 20'h65535, 1'b0};
    tbl[7] = '{2, 10000, 20'h10000, 1'b0};
    tbl[8] = '{0, 9,     20'h00009, 1'b0};

    rst = 1'b1; vld = '0; bin_drv = '0; blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(rdy), 32'h7);
    chk("reset done", 32'(dn), 32'h0);
    chk("reset ovf", 32'(ov), 32'h0);
    chk("reset bcd_c", 32'(bcd_w[2]), 32'h0);
    chk("reset an_a", 32'(an_w[0]), 32'h1E);
    chk("reset seg_a", 32'(seg_w[0]), 32'h3F);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      convert(tbl[i].sel, tbl[i].value, $sformatf("vec%0d", i), gb, go);
      chk($sformatf("vec%0d bcd", i), 32'(gb), 32'(tbl[i].exp_bcd));
      chk($sformatf("vec%0d ovf", i), 32'(go), 32'(tbl[i].exp_ovf));
    end

    convert(0, 7, "scan7", gb, go);
    check_scan(0, 7, 1'b1, "scan7 blank");
    check_scan(0, 7, 1'b0, "scan7 noblank");
    convert(1, 1000, "ovf1000", gb, go);
    check_scan(1, 1000, 1'b1, "ovf1000 dash");
    convert(1, 999, "b999", gb, go);
    chk("b999 bcd", 32'(gb), 32'h999);
    check_scan(2, 10000, 1'b1, "c10000 scan");

    // Held valid: second value is taken only on the first IDLE cycle.
    @(negedge clk);
    bin_drv = 16'd12; vld[0] = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (dn[0]) begin dcyc.push_back(c); dbcd.push_back(bcd_w[0]); end
      if (c == 1)  bin_drv = 16'd34;
      if (c == 4)  bin_drv = 16'd77;
      if (c == 5)  bin_drv = 16'd34;
      if (c == 11) vld[0] = 1'b0;
    end
    chk("hold done_count", 32'(dcyc.size()), 32'd2);
    if (dcyc.size() == 2) begin
      chk("hold done0 cycle", 32'(dcyc[0]), 32'd9);
      chk("hold done1 cycle", 32'(dcyc[1]), 32'd19);
      chk("hold bcd0", 32'(dbcd[0]), 32'h012);
      chk("hold bcd1", 32'(dbcd[1]), 32'h034);
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin_drv = 16'd200; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst bcd", 32'(bcd_w[0]), 32'h0);
    chk("midrst in_ready", 32'(rdy[0]), 32'd1);
    chk("midrst an", 32'(an_w[0]), 32'h1E);
    chk("midrst seg", 32'(seg_w[0]), 32'h3F);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (dn[0]) dcnt++;
      @(negedge clk);
    end
    chk("midrst no_done", 32'(dcnt), 32'd0);
    convert(0, 200, "after_rst", gb, go);
    chk("after_rst bcd", 32'(gb), 32'h200);

    for (int r = 0; r < 24; r++) begin
      int sel = $urandom_range(0, 2);
      int v   = $urandom_range(0, (1 << bw(sel)) - 1);
      int idx;
      blank = 1'($urandom_range(0, 1));
      convert(sel, v, $sformatf("rnd%0d", r), gb, go);
      chk($sformatf("rnd%0d bcd", r), 32'(gb), 32'(m_bcd(v, dg(sel))));
      chk($sformatf("rnd%0d ovf", r), 32'(go), 32'(v >= pow10(dg(sel))));
      for (int j = 0; j < 4; j++) begin
        idx = 0;
        for (int k = 0; k < dg(sel); k++) if (an_w[sel][k] == 1'b0) idx = k;
        chk($sformatf("rnd%0d an", r), 32'(an_w[sel]), 32'(5'b11111 & ~(5'd1 << idx)));
        chk($sformatf("rnd%0d seg", r), 32'(seg_w[sel]), 32'(m_seg(v, dg(sel), idx, blank)));
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
